// File: rtl/crash_pkg.sv
// Shared types and widths for the crash/freeze control slice.
package crash_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FREEZE     = 3'd1,
    WAIT_NOISE = 3'd2,
    RECOVER    = 3'd3,
    GAME_OVER  = 3'd4
  } crash_state_t;

  localparam int LIVES_W = 3;
  localparam int CNT_W   = 24;

endpackage

// File: rtl/frame_counter.sv
// Counts raw frame strobes since the last clear; flags the strobe that
// completes LIMIT frames.
module frame_counter #(
  parameter int unsigned LIMIT = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic strobe_i,
  output logic terminal_o
);

  logic [7:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (strobe_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign terminal_o = strobe_i && (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/crash_freeze_ctrl.sv
// Crash detection, freeze hold, resume tracking and lives/game-over control
// in front of the frame-gate.
module crash_freeze_ctrl
  import crash_pkg::*;
#(
  parameter int unsigned LIVES           = 3,
  parameter int unsigned FREEZE_FRAMES   = 60,
  parameter int unsigned NOISE_WAIT_CYC  = 16,
  parameter int unsigned RECOVER_TIMEOUT = 16_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stratOfFrameIn,
  input  logic       collision,
  input  logic       make_noise,
  input  logic       restart,
  output logic       freeze,
  output logic       crash_pulse,
  output logic       respawn,
  output logic [2:0] lives,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  crash_state_t         state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [CNT_W-1:0]     cyc_cnt_q, cyc_cnt_d;
  logic                 crash_pulse_q, crash_pulse_d;
  logic                 respawn_q, respawn_d;
  logic                 freeze_q, game_over_q;
  logic                 frame_done;

  frame_counter #(
    .LIMIT(FREEZE_FRAMES)
  ) u_freeze_frames (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q != FREEZE),
    .strobe_i  (stratOfFrameIn),
    .terminal_o(frame_done)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    crash_pulse_d = 1'b0;
    respawn_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (stratOfFrameIn && collision) begin
          crash_pulse_d = 1'b1;
          // Also catches lives_q==0, so the count can never wrap.
          if (lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = GAME_OVER;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
            state_d = FREEZE;
          end
        end
      end
      FREEZE: begin
        if (frame_done) begin
          respawn_d = 1'b1;
          state_d   = WAIT_NOISE;
        end
      end
      WAIT_NOISE: begin
        if (make_noise) begin
          state_d = RECOVER;
        end else if (cyc_cnt_q == CNT_W'(NOISE_WAIT_CYC - 1)) begin
          state_d = IDLE;
        end
      end
      RECOVER: begin
        if (!make_noise || cyc_cnt_q == CNT_W'(RECOVER_TIMEOUT - 1)) begin
          state_d = IDLE;
        end
      end
      GAME_OVER: begin
        if (restart) begin
          lives_d   = LIVES_W'(LIVES);
          respawn_d = 1'b1;
          state_d   = WAIT_NOISE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q || !(state_q inside {WAIT_NOISE, RECOVER})) begin
      cyc_cnt_d = '0;
    end else begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      lives_q       <= LIVES_W'(LIVES);
      cyc_cnt_q     <= '0;
      crash_pulse_q <= 1'b0;
      respawn_q     <= 1'b0;
      freeze_q      <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      cyc_cnt_q     <= cyc_cnt_d;
      crash_pulse_q <= crash_pulse_d;
      respawn_q     <= respawn_d;
      freeze_q      <= (state_d == FREEZE) || (state_d == GAME_OVER);
      game_over_q   <= (state_d == GAME_OVER);
    end
  end

  assign freeze      = freeze_q;
  assign crash_pulse = crash_pulse_q;
  assign respawn     = respawn_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_crash_freeze_ctrl.sv
// Randomized-frame bench for crash_freeze_ctrl against a countdown-style
// behavioural model plus a simple frame-gate model.
module tb_crash_freeze_ctrl;

  localparam int unsigned LIVES     = 3;
  localparam int unsigned FF        = 4;
  localparam int unsigned NW        = 8;
  localparam int unsigned RT        = 32;
  localparam int          NOISE_LEN = 20;

  localparam int P_IDLE = 0, P_FRZ = 1, P_WN = 2, P_RC = 3, P_GO = 4;
  localparam int G_NORMAL = 0, G_NONE = 1, G_STUCK = 2;
  localparam logic [9:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 3'd0};

  logic clk = 1'b0;
  logic reset, sof, collision, make_noise, restart;
  logic freeze, crash_pulse, respawn, game_over;
  logic [2:0] lives, state_dbg;

  int errors = 0;
  int checks = 0;

  int m_phase, m_lives, m_left;
  bit m_crash, m_resp;
  int gate_mode, noise_left, gap;

  crash_freeze_ctrl #(
    .LIVES(LIVES), .FREEZE_FRAMES(FF), .NOISE_WAIT_CYC(NW), .RECOVER_TIMEOUT(RT)
  ) dut (
    .clk(clk), .reset(reset), .stratOfFrameIn(sof), .collision(collision),
    .make_noise(make_noise), .restart(restart), .freeze(freeze),
    .crash_pulse(crash_pulse), .respawn(respawn), .lives(lives),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic bit m_freeze();
    return (m_phase == P_FRZ) || (m_phase == P_GO);
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_freeze(), m_crash, m_resp, 3'(m_lives), (m_phase == P_GO), 3'(m_phase)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {freeze, crash_pulse, respawn, lives, game_over, state_dbg};
  endfunction

  function automatic void model_reset();
    m_phase = P_IDLE; m_lives = LIVES; m_left = 0; m_crash = 0; m_resp = 0;
    noise_left = 0;
  endfunction

  // Behaviour written as "frames / cycles left" budgets rather than up-counters.
  function automatic void model_update(input bit s, input bit c, input bit n, input bit r);
    m_crash = 0;
    m_resp  = 0;
    case (m_phase)
      P_IDLE: if (s && c) begin
        m_crash = 1;
        if (m_lives == 1) begin m_lives = 0; m_phase = P_GO; end
        else begin m_lives--; m_phase = P_FRZ; m_left = FF; end
      end
      P_FRZ: if (s) begin
        m_left--;
        if (m_left == 0) begin m_resp = 1; m_phase = P_WN; m_left = NW; end
      end
      P_WN: if (n) begin m_phase = P_RC; m_left = RT; end
            else begin m_left--; if (m_left == 0) m_phase = P_IDLE; end
      P_RC: if (!n) m_phase = P_IDLE;
            else begin m_left--; if (m_left == 0) m_phase = P_IDLE; end
      P_GO: if (r) begin m_lives = LIVES; m_resp = 1; m_phase = P_WN; m_left = NW; end
      default: m_phase = P_IDLE;
    endcase
  endfunction

  // One clock: pick strobe/noise, drive inputs, advance model, sample at +1.
  task automatic step(input logic col, input logic only_gaps, input logic rst_in);
    bit fz_prev;
    if (gap == 0) begin sof = 1'b1; gap = $urandom_range(2, 5); end
    else begin sof = 1'b0; gap--; end
    collision  = only_gaps ? (col & ~sof) : col;
    make_noise = (gate_mode == G_STUCK) || (noise_left > 0);
    restart    = rst_in;
    fz_prev    = m_freeze();
    @(posedge clk);
    model_update(sof, collision, make_noise, restart);
    if (gate_mode == G_NORMAL && fz_prev && !m_freeze()) noise_left = NOISE_LEN;
    else if (noise_left > 0) noise_left--;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; collision = 1'b0; restart = 1'b0; sof = 1'b0; make_noise = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    gap = $urandom_range(1, 4);
  endtask

  task automatic test_reset();
    reset = 1'b1; collision = 1'b0; restart = 1'b0; sof = 1'b0; make_noise = 1'b0;
    #3;
    checks++;
    if (dut_vec() !== RESET_VEC)
      $display("FAIL reset_state: got %b want %b", dut_vec(), RESET_VEC);
    if (dut_vec() !== RESET_VEC) errors++;
    do_reset();
  endtask

  task automatic test_crash_recovery();
    int crashes = 0, fz_str = 0, resp = 0;
    bit crashed = 0, pre_fz, pre_noise;
    do_reset();
    gate_mode = G_NORMAL;
    for (int i = 0; i < 200; i++) begin
      pre_fz = freeze;
      pre_noise = make_noise;
      step(!crashed, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL recovery_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (crash_pulse) begin crashes++; crashed = 1; end
      if (respawn) resp++;
      if (sof && pre_fz) fz_str++;
      if (pre_fz && !freeze) begin
        checks++;
        if (respawn !== 1'b1) begin errors++; $display("FAIL respawn_on_fall: got %b want 1", respawn); end
      end
      if (pre_noise && !make_noise) begin
        checks++;
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL idle_after_noise: got %0d want 0", state_dbg); end
      end
    end
    checks++; if (crashes != 1) begin errors++; $display("FAIL crash_pulse_count: got %0d want 1", crashes); end
    checks++; if (lives !== 3'd2) begin errors++; $display("FAIL lives_after_crash: got %0d want 2", lives); end
    checks++; if (fz_str != FF) begin errors++; $display("FAIL freeze_strobes: got %0d want %0d", fz_str, FF); end
    checks++; if (resp != 1) begin errors++; $display("FAIL respawn_count: got %0d want 1", resp); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL final_idle: got %0d want 0", state_dbg); end
  endtask

  task automatic test_collision_held();
    int crashes = 0;
    bit crashed = 0;
    do_reset();
    gate_mode = G_NORMAL;
    for (int i = 0; i < 200; i++) begin
      step(!(crashed && m_phase == P_IDLE), 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL held_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (crash_pulse) begin crashes++; crashed = 1; end
    end
    checks++; if (crashes != 1) begin errors++; $display("FAIL held_crash_count: got %0d want 1", crashes); end
    checks++; if (lives !== 3'd2) begin errors++; $display("FAIL held_lives: got %0d want 2", lives); end
  endtask

  task automatic test_no_noise();
    int wn = 0, fz_in_wn = 0;
    bit crashed = 0;
    do_reset();
    gate_mode = G_NONE;
    for (int i = 0; i < 120; i++) begin
      step(!crashed, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL no_noise_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (crash_pulse) crashed = 1;
      if (state_dbg == 3'd2) begin wn++; if (freeze) fz_in_wn++; end
    end
    checks++; if (wn != NW) begin errors++; $display("FAIL wait_noise_cycles: got %0d want %0d", wn, NW); end
    checks++; if (fz_in_wn != 0) begin errors++; $display("FAIL freeze_in_wait: got %0d want 0", fz_in_wn); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL no_noise_idle: got %0d want 0", state_dbg); end
  endtask

  task automatic test_game_over();
    int crashes = 0;
    do_reset();
    gate_mode = G_NORMAL;
    for (int i = 0; i < 1500; i++) begin
      step(m_phase == P_IDLE, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL game_over_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (crash_pulse) crashes++;
      if (game_over) break;
    end
    checks++; if (crashes != 3) begin errors++; $display("FAIL go_crash_count: got %0d want 3", crashes); end
    checks++; if ({lives, game_over, freeze} !== {3'd0, 1'b1, 1'b1})
      begin errors++; $display("FAIL go_outputs: got lives=%0d go=%b fz=%b want 0 1 1", lives, game_over, freeze); end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL go_hold_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    step(1'b0, 1'b0, 1'b1);
    checks++; if ({lives, respawn, game_over, freeze} !== {3'd3, 1'b1, 1'b0, 1'b0})
      begin errors++; $display("FAIL restart_outputs: got lives=%0d rs=%b go=%b fz=%b want 3 1 0 0", lives, respawn, game_over, freeze); end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL post_restart_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int fz_str = 0, crashes = 0;
    bit crashed = 0, pre_fz;
    do_reset();
    gate_mode = G_NORMAL;
    for (int i = 0; i < 200; i++) begin
      step(!crashed, 1'b0, 1'b0);
      if (crash_pulse) crashed = 1;
      if (m_phase == P_FRZ && m_left == int'(FF) - 2) break;
    end
    checks++;
    if (state_dbg !== 3'd1) begin errors++; $display("FAIL mid_freeze_reached: got %0d want 1", state_dbg); end
    #2;
    reset = 1'b1; restart = 1'b1; collision = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) begin errors++; $display("FAIL async_reset: got %b want %b", dut_vec(), RESET_VEC); end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin errors++; $display("FAIL reset_beats_restart: got %b want %b", dut_vec(), RESET_VEC); end
    reset = 1'b0; restart = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL restart_in_idle: got %b want %b", dut_vec(), exp_vec()); end
    crashed = 0;
    for (int i = 0; i < 150; i++) begin
      pre_fz = freeze;
      step(!crashed, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fresh_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (crash_pulse) begin crashes++; crashed = 1; end
      if (sof && pre_fz) fz_str++;
    end
    checks++; if (fz_str != FF) begin errors++; $display("FAIL fresh_freeze_strobes: got %0d want %0d", fz_str, FF); end
    checks++; if (crashes != 1 || lives !== 3'd2)
      begin errors++; $display("FAIL fresh_crash: got crashes=%0d lives=%0d want 1 2", crashes, lives); end
  endtask

  task automatic test_nonstrobe_timeout();
    int crashes = 0, rc = 0;
    bit crashed = 0;
    do_reset();
    gate_mode = G_NONE;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (crash_pulse) crashes++;
    end
    checks++; if (crashes != 0 || lives !== 3'd3)
      begin errors++; $display("FAIL nonstrobe_collision: got crashes=%0d lives=%0d want 0 3", crashes, lives); end
    gate_mode = G_STUCK;
    for (int i = 0; i < 150; i++) begin
      step(!crashed, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_cycle %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (crash_pulse) crashed = 1;
      if (state_dbg == 3'd3) rc++;
    end
    checks++; if (rc != RT) begin errors++; $display("FAIL recover_timeout: got %0d want %0d", rc, RT); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL timeout_idle: got %0d want 0", state_dbg); end
  endtask

  initial begin
    gate_mode = G_NORMAL;
    noise_left = 0;
    gap = 1;
    test_reset();
    test_crash_recovery();
    test_collision_held();
    test_no_noise();
    test_game_over();
    test_reset_mid();
    test_nonstrobe_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
